// File: rtl/histogram_cdf_path.sv
// Sweeps the packed histogram in scratch memory, one word per cycle, and writes
// the running cumulative distribution to output memory in the same 4-bin packing.
//
// state   | meaning
// S_IDLE  | waiting for start; outputs hold last sweep's results
// S_RUN   | issuing one histogram read per cycle
// S_DRAIN | reads finished; last in-flight word still to be written
// S_DONE  | final write issued; pulse done and publish total_count next edge
module histogram_cdf_path #(
    parameter int NUM_WORDS  = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int SRC_BASE   = 0,
    parameter int DST_BASE   = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [127:0]          scratch_memory_rdata0,
    output logic [ADDR_WIDTH-1:0] scratch_memory_address_pointer0,
    output logic                  output_memory_write_enable,
    output logic [ADDR_WIDTH-1:0] output_memory_write_address,
    output logic [127:0]          output_memory_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           total_count
);

    localparam int CW = $clog2(NUM_WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   rd_left;
    logic            rd_valid;
    logic [31:0]     acc;
    logic [31:0]     c0, c1, c2, c3;
    logic            start_ok;
    logic            issue;

    assign start_ok = (state == S_IDLE) && start;
    assign issue    = start_ok || (state == S_RUN);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (NUM_WORDS == 1) ? S_DRAIN : S_RUN;
            S_RUN:   if (rd_left == CW'(1)) state_nxt = S_DRAIN;
            S_DRAIN: if (rd_valid) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bin 4w+0 sits in the top lane, so the prefix runs from MSB lane downward.
    always_comb begin
        c0 = acc + scratch_memory_rdata0[127:96];
        c1 = c0  + scratch_memory_rdata0[95:64];
        c2 = c1  + scratch_memory_rdata0[63:32];
        c3 = c2  + scratch_memory_rdata0[31:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch_memory_address_pointer0 <= '0;
            rd_left                         <= '0;
            rd_valid                        <= 1'b0;
            acc                             <= '0;
            output_memory_write_enable      <= 1'b0;
            output_memory_write_address     <= '0;
            output_memory_wdata             <= '0;
            busy                            <= 1'b0;
            done                            <= 1'b0;
            total_count                     <= '0;
        end else begin
            rd_valid                   <= issue;
            output_memory_write_enable <= rd_valid;
            done                       <= (state == S_DONE);

            if (start_ok) begin
                scratch_memory_address_pointer0 <= ADDR_WIDTH'(SRC_BASE);
                rd_left                         <= CW'(NUM_WORDS - 1);
                acc                             <= '0;
                total_count                     <= '0;
                busy                            <= 1'b1;
            end else if (state == S_RUN) begin
                scratch_memory_address_pointer0 <= scratch_memory_address_pointer0 + 1'b1;
                rd_left                         <= rd_left - 1'b1;
            end

            // Address still points at the word whose data is on rdata this cycle.
            if (rd_valid) begin
                output_memory_wdata         <= {c0, c1, c2, c3};
                output_memory_write_address <= scratch_memory_address_pointer0
                                               - ADDR_WIDTH'(SRC_BASE)
                                               + ADDR_WIDTH'(DST_BASE);
                acc                         <= c3;
            end

            if (state == S_DONE) begin
                busy        <= 1'b0;
                total_count <= acc;
            end
        end
    end

endmodule

// File: tb/tb_histogram_cdf_path.sv
// Scoreboard bench for histogram_cdf_path: stimulus pushes expected writes and
// done events; a negedge monitor pops and compares whatever the DUT presents.
module tb_histogram_cdf_path;

    localparam int NW = 64;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         start;
    logic [127:0] rdata;
    logic [15:0]  raddr;
    logic         we;
    logic [15:0]  waddr;
    logic [127:0] wdata;
    logic         busy;
    logic         done;
    logic [31:0]  total_count;

    logic [31:0]  hist [256];
    logic [127:0] mem  [NW];
    int           cyc = 0;
    int           n_assert = 0;
    int           n_fail = 0;

    typedef struct {
        logic [15:0]  a;
        logic [127:0] d;
        int           c;
    } wexp_t;
    typedef struct {
        logic [31:0] t;
        int          c;
    } dexp_t;
    wexp_t wq[$];
    dexp_t dq[$];

    histogram_cdf_path dut (
        .clock                           (clock),
        .reset_n                         (reset_n),
        .start                           (start),
        .scratch_memory_rdata0           (rdata),
        .scratch_memory_address_pointer0 (raddr),
        .output_memory_write_enable      (we),
        .output_memory_write_address     (waddr),
        .output_memory_wdata             (wdata),
        .busy                            (busy),
        .done                            (done),
        .total_count                     (total_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    assign rdata = (raddr < 16'(NW)) ? mem[raddr[5:0]] : '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (we) begin
                if (wq.size() == 0) chk("unexpected_write", 128'(waddr), 128'hDEAD);
                else begin
                    wexp_t e;
                    e = wq.pop_front();
                    chk("write_addr", 128'(waddr), 128'(e.a));
                    chk("write_data", wdata, e.d);
                    chk("write_cycle", 128'(cyc), 128'(e.c));
                    chk("busy_during_write", 128'(busy), 128'(1));
                end
            end
            if (done) begin
                if (dq.size() == 0) chk("unexpected_done", 128'(done), 128'(0));
                else begin
                    dexp_t e;
                    e = dq.pop_front();
                    chk("total_count", 128'(total_count), 128'(e.t));
                    chk("done_cycle", 128'(cyc), 128'(e.c));
                    chk("busy_at_done", 128'(busy), 128'(0));
                end
            end
        end
    end

    // Pack bins into memory, pulse start, and push the expected CDF words.
    task automatic load_and_start(input logic [31:0] exp_total);
        logic [31:0] acc, p0, p1, p2, p3;
        int c0;
        for (int w = 0; w < NW; w++)
            mem[w] = {hist[4*w], hist[4*w+1], hist[4*w+2], hist[4*w+3]};
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        c0 = cyc;
        chk("busy_after_start", 128'(busy), 128'(1));
        acc = 0;
        for (int w = 0; w < NW; w++) begin
            wexp_t e;
            p0 = acc + hist[4*w];
            p1 = p0 + hist[4*w+1];
            p2 = p1 + hist[4*w+2];
            p3 = p2 + hist[4*w+3];
            acc = p3;
            e.a = 16'(w);
            e.d = {p0, p1, p2, p3};
            e.c = c0 + 1 + w;
            wq.push_back(e);
        end
        begin
            dexp_t d;
            d.t = exp_total;
            d.c = c0 + NW + 1;
            dq.push_back(d);
        end
    endtask

    task automatic wait_done(input string nm);
        int i;
        for (i = 0; i < 300; i++) begin
            if (dq.size() == 0) break;
            @(posedge clock);
        end
        if (i == 300) chk({nm, "_timeout"}, 128'(dq.size()), 128'(0));
        repeat (5) @(posedge clock);
        chk({nm, "_writes_left"}, 128'(wq.size()), 128'(0));
        #1;
        chk({nm, "_total_held"}, 128'(total_count), 128'(total_count === 32'hx ? 0 : total_count));
    endtask

    task automatic set_hist(input int mode);
        for (int i = 0; i < 256; i++) begin
            case (mode)
                0: hist[i] = 0;
                1: hist[i] = 1;
                2: hist[i] = (i == 200) ? 32'd5 : 32'd0;
                3: hist[i] = (i == 0) ? 32'hFFFF_FFFF : (i == 1) ? 32'd2 : 32'd0;
                default: hist[i] = 32'(i);
            endcase
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        set_hist(0);
        for (int w = 0; w < NW; w++) mem[w] = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_we", 128'(we), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_total", 128'(total_count), 128'(0));
        chk("rst_raddr", 128'(raddr), 128'(0));
        chk("rst_wdata", wdata, 128'(0));
        @(negedge clock);
        reset_n = 1'b1;

        set_hist(0);
        load_and_start(32'd0);
        wait_done("all_zero");

        set_hist(1);
        load_and_start(32'd256);
        wait_done("all_one");

        set_hist(2);
        load_and_start(32'd5);
        wait_done("single_bin");

        set_hist(3);
        load_and_start(32'd1);
        wait_done("wrap");

        // Ramp 0..255 sums to 32640; extra starts at E10 and in the DONE cycle.
        set_hist(4);
        load_and_start(32'd32640);
        repeat (9) @(posedge clock);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (54) @(posedge clock);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done("ignored_start");
        repeat (80) @(posedge clock);
        chk("no_restart_busy", 128'(busy), 128'(0));

        set_hist(1);
        load_and_start(32'd256);
        repeat (20) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_we", 128'(we), 128'(0));
        chk("midrst_busy", 128'(busy), 128'(0));
        wq.delete();
        dq.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        set_hist(1);
        load_and_start(32'd256);
        wait_done("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
